lg_port_arbiter: RTL and testbench
==================================

# lg_port_arbiter

Sequences and shares the console controller port's single light-sensor (TH) line and the VDP HV-counter latch between two light-gun datapaths. Used for Justifier-style two-gun play and Menacer single-gun play. Each frame it selects one owning gun and forwards only that gun's first valid beam hit. It shapes the hit into a fixed-length sensor pulse with a one-cycle HV latch strobe, then locks out further hits until frame end. It sits between the per-gun lightgun datapaths and the I/O port / VDP.

## Interface
- PULSE_LEN, 64: sensor high time in CE_PIX ticks (1..255).
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE_PIX  in  1  pixel clock enable.
- VDE  in  1  vertical display enable.
- MODE  in  2  0 = gun0 only; 1 = alternate owner each frame; 2 = owner = synchronised SEL; 3 = disabled.
- SEL  in  1  console-driven gun select (port TH output bit), asynchronous.
- HIT  in  2  per-gun one-CLK beam-coincidence strobe.
- VALID  in  2  per-gun status (on-screen, not reloading).
- DRAW  in  2  per-gun crosshair draw request.
- SENSOR  out  1  shared sensor to port.
- HV_LATCH  out  1  one-CLK strobe to VDP HV latch.
- OWNER  out  1  gun currently owning the sensor.
- MISS  out  1  previous frame ended with no accepted hit.
- TARGET  out  3  crosshair code: {both, gun1, gun0}.

## Operation
- Frame start = CE_PIX & rising VDE (previous VDE sampled on CE_PIX). Frame end = CE_PIX & falling VDE.
- States: IDLE, ARMED, PULSE, LOCK.
- IDLE → ARMED at frame start, unless MODE == 3. OWNER is loaded on the same edge:
  - MODE 0: OWNER = 0.
  - MODE 1: OWNER = ~toggle, then toggle flips.
  - MODE 2: OWNER = SEL after two-flop synchroniser.
- ARMED:
  - HIT[OWNER] & VALID[OWNER] → PULSE.
  - Frame end with no such hit → IDLE and MISS = 1.
  - MISS clears on PULSE entry.
- PULSE: SENSOR = 1. Counter is cleared on entry and counts CE_PIX ticks. At count == PULSE_LEN-1 with CE_PIX → LOCK.
- LOCK: SENSOR = 0, all HIT ignored. Frame end → IDLE.
- Frame end during PULSE: pulse completes, then go directly to IDLE (skip LOCK).
- Non-owner HIT, and any HIT outside ARMED: ignored. Simultaneous HIT[0] and HIT[1]: only the owner's counts.
- HIT[OWNER] with VALID[OWNER] = 0: ignored. Stay ARMED.
- MODE or SEL changes mid-frame: take effect at the next frame start only.
- MODE 3: FSM is forced to IDLE on the next CLK, SENSOR = 0, and MISS holds its value.
- TARGET (registered): bit0 = DRAW[0], bit1 = DRAW[1], bit2 = DRAW[0] & DRAW[1]. When bit2 = 1, bits 1:0 = 0.
- Reset (async, any state): state = IDLE, SENSOR = 0, HV_LATCH = 0, OWNER = 0, MISS = 0, TARGET = 0, toggle = 0, synchroniser flops = 0.

## Timing
- Accepted HIT on CLK edge n → SENSOR = 1 and HV_LATCH = 1 from edge n+1. HV_LATCH is high for exactly one CLK.
- SENSOR falls on the CLK edge following the PULSE_LEN-th CE_PIX tick after PULSE entry.
- Entry cycle counts as a tick only if CE_PIX is high on it.
- OWNER is valid from the CLK after frame start and is stable for the whole frame.
- SEL to OWNER: 2 CLK synchroniser latency, plus wait for the next frame start.
- DRAW → TARGET: 1 CLK latency.
- Pulse counter: 8 bits, no wrap; it saturates at 255.

## Structure
- Package lg_pkg holds:
  - state enum lg_arb_state_t {IDLE, ARMED, PULSE, LOCK};
  - MODE constants LG_MODE_SINGLE, LG_MODE_ALT, LG_MODE_SEL, LG_MODE_OFF;
  - TARGET bit indices.
- One sub-module, lg_frame_edge: the SEL two-flop synchroniser plus VDE rise/fall detect qualified by CE_PIX. It outputs frame_start, frame_end and sel_sync.
- Top level holds the FSM, pulse counter, owner/toggle logic and TARGET register.

## Test plan
- MODE 0, PULSE_LEN = 64, CE_PIX every 4 CLK, HIT[0] with VALID[0] mid-frame → HV_LATCH high 1 CLK, SENSOR high 256 CLK, second HIT[0] in the same frame ignored.
- MODE 1 over 4 frames, both guns hitting every frame → OWNER sequence 1, 0, 1, 0. Exactly one SENSOR pulse per frame, always from the owner.
- MODE 2: SEL toggled mid-frame → OWNER unchanged until the next frame start, then equals the new SEL. HIT[~OWNER] → no pulse and MISS = 1 at frame end.
- HIT[0] with VALID[0] = 0 followed by HIT[0] with VALID[0] = 1 → a single pulse, launched from the second hit.
- Hit 10 CE_PIX ticks before VDE falls, PULSE_LEN = 64 → full 64-tick pulse, then IDLE. The next frame arms normally.
- RESET_N asserted mid-PULSE → SENSOR and HV_LATCH drop immediately, state IDLE, OWNER = 0. The next frame start arms the FSM.

Source files
------------

// File: rtl/lg_pkg.sv
// rtl/lg_pkg.sv - shared types and constants for the light-gun port arbiter
package lg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2,
    LOCK  = 2'd3
  } lg_arb_state_t;

  localparam logic [1:0] LG_MODE_SINGLE = 2'd0;
  localparam logic [1:0] LG_MODE_ALT    = 2'd1;
  localparam logic [1:0] LG_MODE_SEL    = 2'd2;
  localparam logic [1:0] LG_MODE_OFF    = 2'd3;

  localparam int LG_TGT_GUN0 = 0;
  localparam int LG_TGT_GUN1 = 1;
  localparam int LG_TGT_BOTH = 2;

endpackage

// File: rtl/lg_frame_edge.sv
// rtl/lg_frame_edge.sv - SEL synchroniser and CE_PIX-qualified VDE edge detect
module lg_frame_edge (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CE_PIX,
  input  logic VDE,
  input  logic SEL,
  output logic frame_start,
  output logic frame_end,
  output logic sel_sync
);

  logic sel_meta;
  logic vde_prev;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
      vde_prev <= 1'b0;
    end else begin
      sel_meta <= SEL;
      sel_sync <= sel_meta;
      // VDE history only advances on pixel ticks so edges line up with CE_PIX
      if (CE_PIX) vde_prev <= VDE;
    end
  end

  assign frame_start = CE_PIX & VDE & ~vde_prev;
  assign frame_end   = CE_PIX & ~VDE & vde_prev;

endmodule

// File: rtl/lg_port_arbiter.sv
// rtl/lg_port_arbiter.sv - per-frame owner selection and sensor pulse shaping for two light guns
module lg_port_arbiter
  import lg_pkg::*;
#(
  parameter int PULSE_LEN = 64
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE_PIX,
  input  logic       VDE,
  input  logic [1:0] MODE,
  input  logic       SEL,
  input  logic [1:0] HIT,
  input  logic [1:0] VALID,
  input  logic [1:0] DRAW,
  output logic       SENSOR,
  output logic       HV_LATCH,
  output logic       OWNER,
  output logic       MISS,
  output logic [2:0] TARGET
);

  localparam logic [7:0] LAST_TICK = 8'(PULSE_LEN - 1);

  lg_arb_state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          toggle_q, toggle_d;
  logic          end_seen_q, end_seen_d;
  logic          owner_d, miss_d, hv_d, sensor_d;
  logic [2:0]    target_d;
  logic          frame_start, frame_end, sel_sync;
  logic          hit_ok, both;

  lg_frame_edge u_frame_edge (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .CE_PIX      (CE_PIX),
    .VDE         (VDE),
    .SEL         (SEL),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .sel_sync    (sel_sync)
  );

  assign hit_ok = HIT[OWNER] & VALID[OWNER];
  assign both   = DRAW[0] & DRAW[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    toggle_d   = toggle_q;
    end_seen_d = end_seen_q;
    owner_d    = OWNER;
    miss_d     = MISS;
    hv_d       = 1'b0;
    if (MODE == LG_MODE_OFF) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_d = ARMED;
            case (MODE)
              LG_MODE_SINGLE: owner_d = 1'b0;
              LG_MODE_ALT: begin
                owner_d  = ~toggle_q;
                toggle_d = ~toggle_q;
              end
              default: owner_d = sel_sync;
            endcase
          end
        end
        ARMED: begin
          if (hit_ok) begin
            state_d    = PULSE;
            hv_d       = 1'b1;
            miss_d     = 1'b0;
            cnt_d      = 8'd0;
            end_seen_d = frame_end;
          end else if (frame_end) begin
            state_d = IDLE;
            miss_d  = 1'b1;
          end
        end
        PULSE: begin
          if (frame_end) end_seen_d = 1'b1;
          if (CE_PIX) begin
            // A frame that already ended skips LOCK so the next frame can arm
            if (cnt_q == LAST_TICK)
              state_d = (end_seen_q | frame_end) ? IDLE : LOCK;
            else if (cnt_q != 8'hFF)
              cnt_d = cnt_q + 8'd1;
          end
        end
        LOCK: begin
          if (frame_end) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    sensor_d = (state_d == PULSE);
    target_d = '0;
    target_d[LG_TGT_BOTH] = both;
    target_d[LG_TGT_GUN0] = DRAW[0] & ~both;
    target_d[LG_TGT_GUN1] = DRAW[1] & ~both;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      toggle_q   <= 1'b0;
      end_seen_q <= 1'b0;
      OWNER      <= 1'b0;
      MISS       <= 1'b0;
      HV_LATCH   <= 1'b0;
      SENSOR     <= 1'b0;
      TARGET     <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      toggle_q   <= toggle_d;
      end_seen_q <= end_seen_d;
      OWNER      <= owner_d;
      MISS       <= miss_d;
      HV_LATCH   <= hv_d;
      SENSOR     <= sensor_d;
      TARGET     <= target_d;
    end
  end

endmodule

// File: tb/tb_lg_port_arbiter.sv
// tb/tb_lg_port_arbiter.sv - directed self-checking bench for lg_port_arbiter
module tb_lg_port_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CE_PIX = 1'b1;
  logic       VDE = 1'b0;
  logic [1:0] MODE = 2'd0;
  logic       SEL = 1'b0;
  logic [1:0] HIT = 2'd0;
  logic [1:0] VALID = 2'd0;
  logic [1:0] DRAW = 2'd0;
  logic       SENSOR, HV_LATCH, OWNER, MISS;
  logic [2:0] TARGET;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ce_div = 1;
  int hi_cnt = 0;
  int pulse_cnt = 0;
  int hv_cnt = 0;
  logic sens_prev = 1'b0;

  lg_port_arbiter #(.PULSE_LEN(64)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .CE_PIX   (CE_PIX),
    .VDE      (VDE),
    .MODE     (MODE),
    .SEL      (SEL),
    .HIT      (HIT),
    .VALID    (VALID),
    .DRAW     (DRAW),
    .SENSOR   (SENSOR),
    .HV_LATCH (HV_LATCH),
    .OWNER    (OWNER),
    .MISS     (MISS),
    .TARGET   (TARGET)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (SENSOR) hi_cnt++;
    if (SENSOR && !sens_prev) pulse_cnt++;
    if (HV_LATCH) hv_cnt++;
    sens_prev = SENSOR;
    cyc++;
    CE_PIX = ((cyc % ce_div) == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    hi_cnt = 0;
    pulse_cnt = 0;
    hv_cnt = 0;
  endtask

  task automatic apply_reset(input int div);
    ce_div = div;
    RESET_N = 1'b0;
    VDE = 1'b0; HIT = 2'd0; VALID = 2'd0; DRAW = 2'd0; SEL = 1'b0;
    steps(2);
    RESET_N = 1'b1;
    steps(2);
    clear_counts();
  endtask

  task automatic wait_ce();
    int n = 0;
    while (!CE_PIX && n < 8) begin
      step();
      n++;
    end
    n_checks++;
    if (!CE_PIX) begin
      n_fail++;
      $display("FAIL wait_ce: CE_PIX=%0b required 1 within 8 cycles", CE_PIX);
    end
  endtask

  task automatic test_reset();
    apply_reset(1);
    n_checks++;
    if ({SENSOR, HV_LATCH, OWNER, MISS, TARGET} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000", {SENSOR, HV_LATCH, OWNER, MISS, TARGET});
    end
  endtask

  task automatic test_target();
    logic [1:0] draws [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [2:0] exp   [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 4; i++) begin
      DRAW = draws[i];
      step();
      n_checks++;
      if (TARGET !== exp[i]) begin
        n_fail++;
        $display("FAIL target_%0d: got %b required %b", i, TARGET, exp[i]);
      end
    end
    DRAW = 2'b00;
  endtask

  task automatic test_single_pulse();
    apply_reset(4);
    MODE = 2'd0;
    VDE = 1'b1;
    steps(8);
    wait_ce();
    clear_counts();
    HIT = 2'b01; VALID = 2'b01;
    step();
    HIT = 2'b00;
    n_checks++;
    if (SENSOR !== 1'b1 || HV_LATCH !== 1'b1) begin
      n_fail++;
      $display("FAIL single_entry: sensor=%b hv=%b required 1 1", SENSOR, HV_LATCH);
    end
    step();
    n_checks++;
    if (HV_LATCH !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hv_width: hv=%b required 0", HV_LATCH);
    end
    steps(100);
    HIT = 2'b01; step(); HIT = 2'b00;
    steps(200);
    HIT = 2'b01; step(); HIT = 2'b00;
    steps(10);
    VDE = 1'b0;
    steps(8);
    n_checks++;
    if (hi_cnt !== 256 || pulse_cnt !== 1 || hv_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_pulse: high=%0d pulses=%0d hv=%0d required 256 1 1", hi_cnt, pulse_cnt, hv_cnt);
    end
  endtask

  task automatic test_alternate();
    logic exp_owner [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset(1);
    MODE = 2'd1;
    VALID = 2'b11;
    for (int f = 0; f < 4; f++) begin
      clear_counts();
      VDE = 1'b1;
      steps(2);
      n_checks++;
      if (OWNER !== exp_owner[f]) begin
        n_fail++;
        $display("FAIL alt_owner_f%0d: got %b required %b", f, OWNER, exp_owner[f]);
      end
      HIT = exp_owner[f] ? 2'b01 : 2'b10;
      step();
      HIT = 2'b00;
      n_checks++;
      if (SENSOR !== 1'b0) begin
        n_fail++;
        $display("FAIL alt_nonowner_f%0d: sensor=%b required 0", f, SENSOR);
      end
      HIT = 2'b11; step(); HIT = 2'b00;
      steps(80);
      n_checks++;
      if (pulse_cnt !== 1 || hv_cnt !== 1 || hi_cnt !== 64 || OWNER !== exp_owner[f]) begin
        n_fail++;
        $display("FAIL alt_frame_f%0d: pulses=%0d hv=%0d high=%0d owner=%b required 1 1 64 %b",
                 f, pulse_cnt, hv_cnt, hi_cnt, OWNER, exp_owner[f]);
      end
      VDE = 1'b0;
      steps(3);
    end
  endtask

  task automatic test_sel_mode();
    apply_reset(1);
    MODE = 2'd2;
    VALID = 2'b11;
    SEL = 1'b0;
    steps(4);
    VDE = 1'b1;
    steps(2);
    SEL = 1'b1;
    steps(5);
    n_checks++;
    if (OWNER !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_midframe_owner: got %b required 0", OWNER);
    end
    HIT = 2'b10; step(); HIT = 2'b00;
    steps(3);
    n_checks++;
    if (SENSOR !== 1'b0 || pulse_cnt !== 0) begin
      n_fail++;
      $display("FAIL sel_nonowner_hit: sensor=%b pulses=%0d required 0 0", SENSOR, pulse_cnt);
    end
    VDE = 1'b0;
    steps(2);
    n_checks++;
    if (MISS !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_miss: got %b required 1", MISS);
    end
    VDE = 1'b1;
    steps(2);
    n_checks++;
    if (OWNER !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_next_owner: got %b required 1", OWNER);
    end
    HIT = 2'b10; step(); HIT = 2'b00;
    n_checks++;
    if (SENSOR !== 1'b1 || MISS !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_owner_hit: sensor=%b miss=%b required 1 0", SENSOR, MISS);
    end
    steps(70);
    VDE = 1'b0;
    steps(2);
  endtask

  task automatic test_valid_gate();
    apply_reset(1);
    MODE = 2'd0;
    VDE = 1'b1;
    steps(2);
    HIT = 2'b01; VALID = 2'b00;
    step();
    HIT = 2'b00;
    n_checks++;
    if (SENSOR !== 1'b0 || HV_LATCH !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_gate_invalid: sensor=%b hv=%b required 0 0", SENSOR, HV_LATCH);
    end
    steps(3);
    HIT = 2'b01; VALID = 2'b01;
    step();
    HIT = 2'b00;
    n_checks++;
    if (HV_LATCH !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_gate_second: hv=%b required 1", HV_LATCH);
    end
    steps(70);
    VDE = 1'b0;
    steps(2);
    n_checks++;
    if (pulse_cnt !== 1 || hi_cnt !== 64) begin
      n_fail++;
      $display("FAIL valid_gate_count: pulses=%0d high=%0d required 1 64", pulse_cnt, hi_cnt);
    end
  endtask

  task automatic test_late_hit();
    apply_reset(4);
    MODE = 2'd0;
    VALID = 2'b01;
    VDE = 1'b1;
    steps(8);
    wait_ce();
    HIT = 2'b01; step(); HIT = 2'b00;
    steps(40);
    VDE = 1'b0;
    steps(260);
    n_checks++;
    if (hi_cnt !== 256 || pulse_cnt !== 1) begin
      n_fail++;
      $display("FAIL late_hit_pulse: high=%0d pulses=%0d required 256 1", hi_cnt, pulse_cnt);
    end
    clear_counts();
    VDE = 1'b1;
    steps(8);
    HIT = 2'b01; step(); HIT = 2'b00;
    n_checks++;
    if (HV_LATCH !== 1'b1 || SENSOR !== 1'b1) begin
      n_fail++;
      $display("FAIL late_hit_rearm: hv=%b sensor=%b required 1 1", HV_LATCH, SENSOR);
    end
    steps(260);
    VDE = 1'b0;
    steps(8);
  endtask

  task automatic test_mode_off();
    apply_reset(1);
    MODE = 2'd0;
    VALID = 2'b01;
    VDE = 1'b1;
    steps(2);
    HIT = 2'b01; step(); HIT = 2'b00;
    steps(5);
    MODE = 2'd3;
    step();
    n_checks++;
    if (SENSOR !== 1'b0) begin
      n_fail++;
      $display("FAIL off_sensor: got %b required 0", SENSOR);
    end
    VDE = 1'b0;
    steps(2);
    MODE = 2'd0;
    VDE = 1'b1;
    steps(3);
    VDE = 1'b0;
    steps(2);
    MODE = 2'd3;
    clear_counts();
    VDE = 1'b1;
    steps(3);
    HIT = 2'b01; step(); HIT = 2'b00;
    steps(3);
    VDE = 1'b0;
    steps(3);
    n_checks++;
    if (MISS !== 1'b1 || pulse_cnt !== 0 || hv_cnt !== 0) begin
      n_fail++;
      $display("FAIL off_frame: miss=%b pulses=%0d hv=%0d required 1 0 0", MISS, pulse_cnt, hv_cnt);
    end
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset(1);
    MODE = 2'd1;
    VALID = 2'b11;
    DRAW = 2'b11;
    VDE = 1'b1;
    steps(2);
    HIT = 2'b10; step(); HIT = 2'b00;
    steps(10);
    n_checks++;
    if (SENSOR !== 1'b1 || OWNER !== 1'b1 || TARGET !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_pre: sensor=%b owner=%b target=%b required 1 1 100", SENSOR, OWNER, TARGET);
    end
    #3;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({SENSOR, HV_LATCH, OWNER, MISS, TARGET} !== 7'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %b required 0000000", {SENSOR, HV_LATCH, OWNER, MISS, TARGET});
    end
    DRAW = 2'b00;
    step();
    RESET_N = 1'b1;
    clear_counts();
    steps(2);
    HIT = 2'b10; step(); HIT = 2'b00;
    n_checks++;
    if (HV_LATCH !== 1'b1 || OWNER !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rearm: hv=%b owner=%b required 1 1", HV_LATCH, OWNER);
    end
    steps(70);
    VDE = 1'b0;
    steps(2);
  endtask

  initial begin
    test_reset();
    test_target();
    test_single_pulse();
    test_alternate();
    test_sel_mode();
    test_valid_gate();
    test_late_hit();
    test_mode_off();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
